// File: rtl/board_mem_arbiter_pkg.sv
// Shared types and board-wide sizes for the cell-memory arbiter.
package board_mem_arbiter_pkg;
  localparam int unsigned LOG_MAX_ADDR = 16;
  localparam int unsigned LINE_WIDTH   = 32;

  typedef enum logic [1:0] {TAG_NONE, TAG_REND, TAG_ENG} arb_tag_t;
endpackage

// File: rtl/board_mem_arbiter_tag_pipe.sv
// Fixed-depth shift register of read tags; clear flushes reads in flight.
module arb_tag_pipe
  import board_mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic     clk,
  input  logic     clr,
  input  arb_tag_t tag_in,
  output arb_tag_t tag_out
);

  arb_tag_t stages [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) stages[i] <= TAG_NONE;
    end else begin
      stages[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/board_mem_arbiter.sv
// Arbitrates the single-port cell BRAM between the renderer fetch and the
// life-step engine, routing tagged read data back after a fixed latency.
module board_mem_arbiter
  import board_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = LOG_MAX_ADDR,
  parameter int unsigned DATA_W       = LINE_WIDTH,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              blank_in,
  input  logic              rend_req_in,
  input  logic [ADDR_W-1:0] rend_addr_in,
  output logic              rend_gnt_out,
  output logic              rend_valid_out,
  output logic [DATA_W-1:0] rend_data_out,
  input  logic              eng_req_in,
  input  logic              eng_we_in,
  input  logic [ADDR_W-1:0] eng_addr_in,
  input  logic [DATA_W-1:0] eng_wdata_in,
  output logic              eng_gnt_out,
  output logic              eng_valid_out,
  output logic [DATA_W-1:0] eng_data_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_we_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  input  logic [DATA_W-1:0] mem_data_in
);

  localparam int unsigned       CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             eng_wins;
  arb_tag_t         tag_issue;
  arb_tag_t         tag_ret;

  // Engine wins during blanking, on a forced slot, or when the renderer is idle.
  always_comb begin
    eng_wins     = eng_req_in && (blank_in || (starve_cnt == LIMIT) || !rend_req_in);
    eng_gnt_out  = !rst_in && eng_wins;
    rend_gnt_out = !rst_in && rend_req_in && !eng_wins;
    tag_issue    = TAG_NONE;
    if (eng_gnt_out && !eng_we_in) tag_issue = TAG_ENG;
    else if (rend_gnt_out)         tag_issue = TAG_REND;
  end

  arb_tag_pipe #(
    .DEPTH (1 + MEM_LATENCY)
  ) u_tag_pipe (
    .clk     (clk_in),
    .clr     (rst_in),
    .tag_in  (tag_issue),
    .tag_out (tag_ret)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      starve_cnt     <= '0;
      mem_addr_out   <= '0;
      mem_we_out     <= 1'b0;
      mem_wdata_out  <= '0;
      rend_valid_out <= 1'b0;
      rend_data_out  <= '0;
      eng_valid_out  <= 1'b0;
      eng_data_out   <= '0;
    end else begin
      if (eng_gnt_out || !eng_req_in)
        starve_cnt <= '0;
      else if (rend_gnt_out && (starve_cnt != LIMIT))
        starve_cnt <= starve_cnt + 1'b1;

      mem_we_out <= eng_gnt_out && eng_we_in;
      if (eng_gnt_out) begin
        mem_addr_out  <= eng_addr_in;
        mem_wdata_out <= eng_wdata_in;
      end else if (rend_gnt_out) begin
        mem_addr_out  <= rend_addr_in;
      end

      rend_valid_out <= (tag_ret == TAG_REND);
      eng_valid_out  <= (tag_ret == TAG_ENG);
      if (tag_ret == TAG_REND) rend_data_out <= mem_data_in;
      if (tag_ret == TAG_ENG)  eng_data_out  <= mem_data_in;
    end
  end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a 2-cycle BRAM model.
module tb_board_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        blank;
  logic        rend_req;
  logic [15:0] rend_addr;
  logic        rend_gnt;
  logic        rend_valid;
  logic [31:0] rend_data;
  logic        eng_req;
  logic        eng_we;
  logic [15:0] eng_addr;
  logic [31:0] eng_wdata;
  logic        eng_gnt;
  logic        eng_valid;
  logic [31:0] eng_data;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_data;

  always #5 clk = ~clk;

  board_mem_arbiter #(
    .ADDR_W       (16),
    .DATA_W       (32),
    .MEM_LATENCY  (2),
    .STARVE_LIMIT (8)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .blank_in       (blank),
    .rend_req_in    (rend_req),
    .rend_addr_in   (rend_addr),
    .rend_gnt_out   (rend_gnt),
    .rend_valid_out (rend_valid),
    .rend_data_out  (rend_data),
    .eng_req_in     (eng_req),
    .eng_we_in      (eng_we),
    .eng_addr_in    (eng_addr),
    .eng_wdata_in   (eng_wdata),
    .eng_gnt_out    (eng_gnt),
    .eng_valid_out  (eng_valid),
    .eng_data_out   (eng_data),
    .mem_addr_out   (mem_addr),
    .mem_we_out     (mem_we),
    .mem_wdata_out  (mem_wdata),
    .mem_data_in    (mem_data)
  );

  // BRAM model: address registered in, data out two cycles later.
  logic [31:0] mem [0:65535];
  logic [31:0] mem_d1;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_d1   <= mem[mem_addr];
    mem_data <= mem_d1;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          at;
    logic [31:0] data;
  } ret_t;
  ret_t rend_q[$];
  ret_t eng_q[$];
  int   we_cnt = 0;

  always @(negedge clk) begin
    if (rend_valid) rend_q.push_back('{cyc, rend_data});
    if (eng_valid)  eng_q.push_back('{cyc, eng_data});
    if (mem_we)     we_cnt++;
  end

  int n_checked = 0;
  int n_bad     = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checked++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rend_q.delete();
    eng_q.delete();
    we_cnt = 0;
  endtask

  task automatic check_ret(input string tag, input ret_t r, input int at, input logic [31:0] data);
    check_eq({tag, "_cycle"}, r.at, at);
    check_eq({tag, "_data"}, r.data, data);
  endtask

  int t0;
  int tacc [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; blank = 1'b0;
    rend_req = 1'b0; rend_addr = '0;
    eng_req = 1'b0; eng_we = 1'b0; eng_addr = '0; eng_wdata = '0;
    mem[16'h0010] = 32'h0BAD_0010;
    mem[16'h0042] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) mem[16'h0200 + i] = 32'hA000_0000 + i;

    repeat (3) tick();
    rend_req = 1'b1; eng_req = 1'b1; rend_addr = 16'h0010;
    @(negedge clk);
    check_eq("rst_rend_gnt", rend_gnt, 0);
    check_eq("rst_eng_gnt", eng_gnt, 0);
    check_eq("rst_ctl", {rend_valid, eng_valid, mem_we}, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_data", {rend_data, eng_data}, 0);

    // Reset pulse one cycle after an accepted read must suppress its return.
    tick();
    rst = 1'b0; eng_req = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_gnt", rend_gnt, 1);
    tick();
    rend_req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ctl", {rend_valid, eng_valid, mem_we}, 0);
    check_eq("post_rst_addr", mem_addr, 0);
    check_eq("post_rst_wdata", mem_wdata, 0);
    repeat (6) tick();
    check_eq("mid_rst_no_valid", rend_q.size(), 0);

    // Single renderer read.
    clear_logs();
    rend_req = 1'b1; rend_addr = 16'h0042;
    @(negedge clk);
    check_eq("single_gnt", rend_gnt, 1);
    t0 = cyc;
    tick();
    rend_req = 1'b0;
    @(negedge clk);
    check_eq("single_mem_addr", mem_addr, 16'h0042);
    check_eq("single_mem_we", mem_we, 0);
    repeat (6) tick();
    @(negedge clk);
    check_eq("single_addr_hold", mem_addr, 16'h0042);
    check_eq("single_rend_cnt", rend_q.size(), 1);
    check_eq("single_eng_cnt", eng_q.size(), 0);
    if (rend_q.size() == 1) check_ret("single", rend_q[0], t0 + 4, 32'hDEAD_BEEF);

    // Contention in active video: 8 renderer slots then one forced engine slot.
    tick();
    rend_req = 1'b1; rend_addr = 16'h0042;
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 16'h0010;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      check_eq($sformatf("cont_rend_gnt_%0d", i), rend_gnt, (i % 9) != 8);
      check_eq($sformatf("cont_eng_gnt_%0d", i), eng_gnt, (i % 9) == 8);
      tick();
    end
    rend_req = 1'b0; eng_req = 1'b0;
    repeat (6) tick();

    // Blanking gives the engine priority; renderer only when engine idle.
    blank = 1'b1; rend_req = 1'b1; eng_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("blank_eng_gnt_%0d", i), eng_gnt, 1);
      check_eq($sformatf("blank_rend_gnt_%0d", i), rend_gnt, 0);
      tick();
    end
    eng_req = 1'b0;
    @(negedge clk);
    check_eq("blank_idle_rend_gnt", rend_gnt, 1);
    check_eq("blank_idle_eng_gnt", eng_gnt, 0);
    tick();
    blank = 1'b0; eng_req = 1'b1;
    @(negedge clk);
    check_eq("blank_fall_rend_gnt", rend_gnt, 1);
    check_eq("blank_fall_eng_gnt", eng_gnt, 0);
    tick();
    rend_req = 1'b0; eng_req = 1'b0;
    repeat (6) tick();

    // Engine write then read of the same address.
    clear_logs();
    eng_req = 1'b1; eng_we = 1'b1; eng_addr = 16'h0100; eng_wdata = 32'h1234_5678;
    @(negedge clk);
    check_eq("wr_gnt", eng_gnt, 1);
    tick();
    eng_we = 1'b0;
    @(negedge clk);
    check_eq("rd_gnt", eng_gnt, 1);
    check_eq("wr_mem_we", mem_we, 1);
    check_eq("wr_mem_addr", mem_addr, 16'h0100);
    check_eq("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    t0 = cyc;
    tick();
    eng_req = 1'b0;
    @(negedge clk);
    check_eq("rd_mem_we", mem_we, 0);
    repeat (6) tick();
    check_eq("wr_we_pulses", we_cnt, 1);
    check_eq("wr_rend_cnt", rend_q.size(), 0);
    check_eq("wr_eng_cnt", eng_q.size(), 1);
    if (eng_q.size() == 1) check_ret("raw", eng_q[0], t0 + 4, 32'h1234_5678);

    // Alternating renderer/engine reads on back-to-back cycles.
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      rend_req = (i % 2) == 0;
      eng_req  = (i % 2) == 1;
      rend_addr = 16'h0200 + 16'(i);
      eng_addr  = 16'h0200 + 16'(i);
      @(negedge clk);
      check_eq($sformatf("il_gnt_%0d", i), {rend_gnt, eng_gnt}, ((i % 2) == 0) ? 2'b10 : 2'b01);
      tacc[i] = cyc;
      tick();
    end
    rend_req = 1'b0; eng_req = 1'b0;
    repeat (7) tick();
    check_eq("il_rend_cnt", rend_q.size(), 2);
    check_eq("il_eng_cnt", eng_q.size(), 2);
    if (rend_q.size() == 2) begin
      check_ret("il_rend0", rend_q[0], tacc[0] + 4, 32'hA000_0000);
      check_ret("il_rend1", rend_q[1], tacc[2] + 4, 32'hA000_0002);
    end
    if (eng_q.size() == 2) begin
      check_ret("il_eng0", eng_q[0], tacc[1] + 4, 32'hA000_0001);
      check_ret("il_eng1", eng_q[1], tacc[3] + 4, 32'hA000_0003);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_bad);
    $finish;
  end

endmodule
